trivium_ctrl: RTL and testbench

- Sequencer for the Trivium cipher engine.
- On start it resets the engine and loads an 80-bit key into register A and an 80-bit IV into register B, 32 bits per cycle.
- It then runs the warm-up rounds and streams data words through the engine one bit per cycle, returning cipher/plain words.
- It sits between the host word interface and the bit-serial engine.

---
 rtl/trivium_ctrl.sv | 152 +++++++++++++++
 tb/tb_trivium_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trivium_ctrl.sv
// rtl/trivium_ctrl.sv - Trivium engine sequencer: key/IV load, warm-up, then word-to-bit streaming.
// Optional macro TRIVIUM_CTRL_BITCNT_EN adds bit_cnt_o (saturating count of streamed engine cycles).
module trivium_ctrl #(
  parameter int DAT_W      = 8,
  parameter int WARMUP_CYC = 1152
) (
  input  logic             clk_i,
  input  logic             n_rst_i,
  input  logic             start_i,
  input  logic [79:0]      key_i,
  input  logic [79:0]      iv_i,
  output logic             rdy_o,
  input  logic             in_vld_i,
  input  logic [DAT_W-1:0] in_dat_i,
  output logic             in_rdy_o,
  output logic             out_vld_o,
  output logic [DAT_W-1:0] out_dat_o,
  input  logic             out_rdy_i,
  output logic             eng_n_rst_o,
  output logic             eng_ce_o,
  output logic [31:0]      eng_ld_dat_o,
  output logic [2:0]       eng_ld_a_o,
  output logic [2:0]       eng_ld_b_o,
  output logic             eng_dat_o,
  input  logic             eng_dat_i
`ifdef TRIVIUM_CTRL_BITCNT_EN
  ,
  output logic [31:0]      bit_cnt_o
`endif
);
  localparam int BCW = $clog2(DAT_W + 1);
  localparam int WCW = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;
  localparam logic [BCW-1:0] BITS      = BCW'(DAT_W);
  localparam logic [WCW-1:0] WARM_LAST = WCW'(WARMUP_CYC - 1);

  typedef enum logic [2:0] {IDLE, INIT, LD_KEY, LD_IV, WARM, STREAM} state_t;
  state_t state, state_nxt;

  logic [79:0]      key_q, iv_q, ld_src;
  logic [1:0]       wd_idx;
  logic [WCW-1:0]   warm_cnt;
  logic [BCW-1:0]   bit_left;
  logic [DAT_W-1:0] in_sr, out_sr;
  logic             start_acc, word_acc, bit_busy;

  assign bit_busy  = (bit_left != '0);
  assign start_acc = start_i && ((state == IDLE) || ((state == STREAM) && !bit_busy));
  // A start offered together with a word wins; the word belongs to the discarded session.
  assign word_acc  = in_vld_i && in_rdy_o && !start_acc;
  assign out_dat_o = out_sr;

  always_comb begin
    state_nxt    = state;
    rdy_o        = 1'b0;
    in_rdy_o     = 1'b0;
    eng_ce_o     = 1'b0;
    eng_ld_dat_o = '0;
    eng_ld_a_o   = '0;
    eng_ld_b_o   = '0;
    eng_dat_o    = 1'b0;
    ld_src       = (state == LD_IV) ? iv_q : key_q;
    case (state)
      IDLE: if (start_acc) state_nxt = INIT;
      INIT: state_nxt = LD_KEY;
      LD_KEY, LD_IV: begin
        eng_ce_o = 1'b1;
        case (wd_idx)
          2'd0:    eng_ld_dat_o = ld_src[31:0];
          2'd1:    eng_ld_dat_o = ld_src[63:32];
          default: eng_ld_dat_o = {16'b0, ld_src[79:64]};
        endcase
        if (state == LD_KEY) eng_ld_a_o = 3'b001 << wd_idx;
        else                 eng_ld_b_o = 3'b001 << wd_idx;
        if (wd_idx == 2'd2) state_nxt = (state == LD_KEY) ? LD_IV : WARM;
      end
      WARM: begin
        eng_ce_o = 1'b1;
        if (warm_cnt == '0) state_nxt = STREAM;
      end
      STREAM: begin
        rdy_o     = 1'b1;
        in_rdy_o  = !bit_busy && (!out_vld_o || out_rdy_i);
        eng_ce_o  = bit_busy;
        eng_dat_o = bit_busy && in_sr[0];
        if (start_acc) state_nxt = INIT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Engine reset is registered so it is held low through reset and the INIT cycle only.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state       <= IDLE;
      eng_n_rst_o <= 1'b0;
    end else begin
      state       <= state_nxt;
      eng_n_rst_o <= (state_nxt != INIT);
    end
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      key_q     <= '0;
      iv_q      <= '0;
      wd_idx    <= '0;
      warm_cnt  <= '0;
      bit_left  <= '0;
      in_sr     <= '0;
      out_sr    <= '0;
      out_vld_o <= 1'b0;
    end else begin
      if (start_acc) begin
        key_q <= key_i;
        iv_q  <= iv_i;
      end
      wd_idx <= ((state inside {LD_KEY, LD_IV}) && (wd_idx != 2'd2)) ? wd_idx + 2'd1 : 2'd0;
      if (state == LD_IV)
        warm_cnt <= WARM_LAST;
      else if ((state == WARM) && (warm_cnt != '0))
        warm_cnt <= warm_cnt - WCW'(1);
      // Bits enter LSB-first and results shift in from the top so the first bit lands in bit 0.
      if (word_acc) begin
        in_sr    <= in_dat_i;
        bit_left <= BITS;
      end else if (bit_busy) begin
        in_sr    <= in_sr >> 1;
        out_sr   <= (out_sr >> 1) | (DAT_W'(eng_dat_i) << (DAT_W - 1));
        bit_left <= bit_left - BCW'(1);
      end
      if (start_acc)
        out_vld_o <= 1'b0;
      else if (bit_left == BCW'(1))
        out_vld_o <= 1'b1;
      else if (out_rdy_i)
        out_vld_o <= 1'b0;
    end
  end

`ifdef TRIVIUM_CTRL_BITCNT_EN
  logic [31:0] bit_cnt_q;
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i)
      bit_cnt_q <= '0;
    else if (state == INIT)
      bit_cnt_q <= '0;
    else if ((state == STREAM) && bit_busy && (bit_cnt_q != 32'hFFFF_FFFF))
      bit_cnt_q <= bit_cnt_q + 32'd1;
  end
  assign bit_cnt_o = bit_cnt_q;
`endif
endmodule

// File: tb/tb_trivium_ctrl.sv
// tb/tb_trivium_ctrl.sv - directed self-checking bench for trivium_ctrl with a bit-serial engine stand-in.
module tb_trivium_ctrl;
  localparam int WARM = 1152;
  localparam logic [79:0] K1 = 80'h0123456789ABCDEF0123;
  localparam logic [79:0] V1 = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
  localparam logic [79:0] K2 = 80'hDEADBEEFCAFEF00D1234;
  localparam logic [79:0] V2 = 80'h0F1E2D3C4B5A69788796;

  logic        clk_i = 1'b0;
  logic        n_rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic [79:0] key_i = '0;
  logic [79:0] iv_i = '0;
  logic        rdy_o;
  logic        in_vld_i = 1'b0;
  logic [7:0]  in_dat_i = '0;
  logic        in_rdy_o;
  logic        out_vld_o;
  logic [7:0]  out_dat_o;
  logic        out_rdy_i = 1'b0;
  logic        eng_n_rst_o;
  logic        eng_ce_o;
  logic [31:0] eng_ld_dat_o;
  logic [2:0]  eng_ld_a_o;
  logic [2:0]  eng_ld_b_o;
  logic        eng_dat_o;
  logic        eng_dat_i;
`ifdef TRIVIUM_CTRL_BITCNT_EN
  logic [31:0] bit_cnt_o;
`endif

  int vec = 0;
  int err = 0;
  int words_done = 0;
  logic [31:0] m_s;
  logic [31:0] eng_s;

  always #5 clk_i = ~clk_i;

  trivium_ctrl #(.DAT_W(8), .WARMUP_CYC(WARM)) dut (
    .clk_i(clk_i), .n_rst_i(n_rst_i), .start_i(start_i), .key_i(key_i), .iv_i(iv_i),
    .rdy_o(rdy_o), .in_vld_i(in_vld_i), .in_dat_i(in_dat_i), .in_rdy_o(in_rdy_o),
    .out_vld_o(out_vld_o), .out_dat_o(out_dat_o), .out_rdy_i(out_rdy_i),
    .eng_n_rst_o(eng_n_rst_o), .eng_ce_o(eng_ce_o), .eng_ld_dat_o(eng_ld_dat_o),
    .eng_ld_a_o(eng_ld_a_o), .eng_ld_b_o(eng_ld_b_o), .eng_dat_o(eng_dat_o), .eng_dat_i(eng_dat_i)
`ifdef TRIVIUM_CTRL_BITCNT_EN
    , .bit_cnt_o(bit_cnt_o)
`endif
  );

  function automatic logic [31:0] ld_step(input logic [31:0] s, input logic [31:0] d, input bit is_b);
    return {s[30:0], s[31]} ^ d ^ (is_b ? 32'h5A5A_0000 : 32'h0);
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C1_1DB7 : 32'h0);
  endfunction

  function automatic logic [31:0] model_init(input logic [79:0] k, input logic [79:0] v);
    logic [31:0] s;
    s = '0;
    s = ld_step(s, k[31:0], 1'b0);
    s = ld_step(s, k[63:32], 1'b0);
    s = ld_step(s, {16'h0, k[79:64]}, 1'b0);
    s = ld_step(s, v[31:0], 1'b1);
    s = ld_step(s, v[63:32], 1'b1);
    s = ld_step(s, {16'h0, v[79:64]}, 1'b1);
    for (int i = 0; i < WARM; i++) s = lfsr_step(s);
    return s;
  endfunction

  always @(posedge clk_i) begin
    if (!eng_n_rst_o) eng_s <= '0;
    else if (eng_ce_o) begin
      if (|eng_ld_a_o)      eng_s <= ld_step(eng_s, eng_ld_dat_o, 1'b0);
      else if (|eng_ld_b_o) eng_s <= ld_step(eng_s, eng_ld_dat_o, 1'b1);
      else                  eng_s <= lfsr_step(eng_s);
    end
  end
  assign eng_dat_i = eng_dat_o ^ eng_s[0];

  task automatic tick;
    @(posedge clk_i);
    #2;
  endtask

  task automatic model_word(input logic [7:0] d, output logic [7:0] e);
    for (int i = 0; i < 8; i++) begin
      e[i] = d[i] ^ m_s[0];
      m_s = lfsr_step(m_s);
    end
  endtask

  task automatic test_reset;
    n_rst_i = 1'b0;
    tick; tick;
    vec++;
    if ({rdy_o, in_rdy_o, out_vld_o, out_dat_o, eng_n_rst_o, eng_ce_o, eng_ld_dat_o, eng_ld_a_o, eng_ld_b_o, eng_dat_o} !== '0) begin
      err++; $display("FAIL reset_outputs: got vld=%b dat=%h nrst=%b ce=%b lda=%b ldb=%b, want all 0", out_vld_o, out_dat_o, eng_n_rst_o, eng_ce_o, eng_ld_a_o, eng_ld_b_o);
    end
    n_rst_i = 1'b1;
    tick;
    vec++;
    if (eng_n_rst_o !== 1'b1 || rdy_o !== 1'b0) begin
      err++; $display("FAIL reset_release: eng_n_rst=%b rdy=%b, want 1 0", eng_n_rst_o, rdy_o);
    end
  endtask

  task automatic init_seq(input logic [79:0] k, input logic [79:0] v, input bit poke);
    logic [79:0] src;
    logic [31:0] exp_dat;
    logic [2:0] exp_a, exp_b;
    int n, w;
    bit bad;
    key_i = k; iv_i = v; start_i = 1'b1;
    tick;
    start_i = 1'b0; key_i = '0; iv_i = '0;
    vec++;
    if (eng_n_rst_o !== 1'b0 || eng_ce_o !== 1'b0 || out_vld_o !== 1'b0 || rdy_o !== 1'b0) begin
      err++; $display("FAIL init_cycle: nrst=%b ce=%b vld=%b rdy=%b, want 0 0 0 0", eng_n_rst_o, eng_ce_o, out_vld_o, rdy_o);
    end
    tick;
    for (int i = 0; i < 6; i++) begin
      src = (i < 3) ? k : v;
      w = i % 3;
      exp_dat = (w == 0) ? src[31:0] : (w == 1) ? src[63:32] : {16'h0, src[79:64]};
      exp_a = (i < 3) ? (3'b001 << w) : 3'b000;
      exp_b = (i < 3) ? 3'b000 : (3'b001 << w);
      vec++;
      if ({eng_n_rst_o, eng_ce_o, eng_ld_a_o, eng_ld_b_o, eng_ld_dat_o} !== {1'b1, 1'b1, exp_a, exp_b, exp_dat}) begin
        err++; $display("FAIL load_%0d: nrst=%b ce=%b a=%b b=%b dat=%h, want 1 1 %b %b %h", i, eng_n_rst_o, eng_ce_o, eng_ld_a_o, eng_ld_b_o, eng_ld_dat_o, exp_a, exp_b, exp_dat);
      end
      tick;
    end
    n = 0; bad = 1'b0;
    while (!rdy_o && n < 2000) begin
      if (eng_ce_o !== 1'b1 || eng_dat_o !== 1'b0 || eng_ld_a_o !== 3'b0 || eng_ld_b_o !== 3'b0 || eng_n_rst_o !== 1'b1) bad = 1'b1;
      start_i = (poke && n == 500);
      n++;
      tick;
    end
    start_i = 1'b0;
    vec++;
    if (n !== WARM) begin
      err++; $display("FAIL warm_length: rdy after %0d cycles, want %0d", n, WARM);
    end
    vec++;
    if (bad) begin
      err++; $display("FAIL warm_controls: got irregular ce/dat/ld during warm-up, want ce=1 dat=0 ld=0");
    end
    m_s = model_init(k, v);
    words_done = 0;
`ifdef TRIVIUM_CTRL_BITCNT_EN
    vec++;
    if (bit_cnt_o !== 32'd0) begin
      err++; $display("FAIL bitcnt_after_init: got %0d, want 0", bit_cnt_o);
    end
`endif
  endtask

  task automatic xfer(input logic [7:0] d, input bit poke, output logic [7:0] got);
    logic [7:0] e;
    int n;
    model_word(d, e);
    n = 0;
    while (!in_rdy_o && n < 100) begin n++; tick; end
    in_vld_i = 1'b1; in_dat_i = d;
    tick;
    in_vld_i = 1'b0; in_dat_i = '0;
    n = 1;
    while (!out_vld_o && n < 50) begin
      start_i = (poke && n == 3);
      n++;
      tick;
    end
    start_i = 1'b0;
    vec++;
    if (n !== 9 || rdy_o !== 1'b1) begin
      err++; $display("FAIL word_latency: got %0d cycles rdy=%b, want 9 rdy=1", n, rdy_o);
    end
    vec++;
    if (out_dat_o !== e) begin
      err++; $display("FAIL word_data: in=%h got %h, want %h", d, out_dat_o, e);
    end
    got = out_dat_o;
    out_rdy_i = 1'b1;
    tick;
    out_rdy_i = 1'b0;
    words_done++;
  endtask

  task automatic test_keystream;
    logic [7:0] got;
    init_seq(K1, V1, 1'b1);
    for (int i = 0; i < 16; i++) xfer(8'h00, (i == 5), got);
`ifdef TRIVIUM_CTRL_BITCNT_EN
    vec++;
    if (bit_cnt_o !== 32'(8 * words_done)) begin
      err++; $display("FAIL bitcnt_words: got %0d, want %0d", bit_cnt_o, 8 * words_done);
    end
`endif
  endtask

  task automatic test_stall;
    logic [7:0] e0, e1, held;
    int n;
    bit bad;
    model_word(8'hA5, e0);
    in_vld_i = 1'b1; in_dat_i = 8'hA5;
    tick;
    in_vld_i = 1'b0;
    n = 0;
    while (!out_vld_o && n < 50) begin n++; tick; end
    vec++;
    if (out_dat_o !== e0) begin
      err++; $display("FAIL stall_first: got %h, want %h", out_dat_o, e0);
    end
    held = out_dat_o; bad = 1'b0;
    in_vld_i = 1'b1; in_dat_i = 8'h3C;
    repeat (20) begin
      #1;
      if (out_vld_o !== 1'b1 || out_dat_o !== held || in_rdy_o !== 1'b0 || eng_ce_o !== 1'b0) bad = 1'b1;
      tick;
    end
    vec++;
    if (bad) begin
      err++; $display("FAIL stall_hold: got output/handshake/ce change during stall, want held %h", held);
    end
    model_word(8'h3C, e1);
    out_rdy_i = 1'b1;
    #1;
    vec++;
    if (in_rdy_o !== 1'b1) begin
      err++; $display("FAIL stall_release_accept: in_rdy=%b, want 1", in_rdy_o);
    end
    tick;
    out_rdy_i = 1'b0; in_vld_i = 1'b0;
    n = 1;
    while (!out_vld_o && n < 50) begin n++; tick; end
    vec++;
    if (n !== 9 || out_dat_o !== e1) begin
      err++; $display("FAIL stall_resume: got %h after %0d, want %h after 9", out_dat_o, n, e1);
    end
    out_rdy_i = 1'b1;
    tick;
    out_rdy_i = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [7:0] q[$];
    logic [7:0] d, e;
    int n, outs, last_t;
    bit acc_prev;
    d = 8'h11; outs = 0; last_t = -1; acc_prev = 1'b0; n = 0;
    out_rdy_i = 1'b1; in_vld_i = 1'b1; in_dat_i = d;
    while (outs < 4 && n < 200) begin
      if (acc_prev) begin d = d + 8'h22; in_dat_i = d; end
      #1;
      if (out_vld_o) begin
        e = q.pop_front();
        vec++;
        if (out_dat_o !== e) begin
          err++; $display("FAIL b2b_data_%0d: got %h, want %h", outs, out_dat_o, e);
        end
        if (last_t >= 0) begin
          vec++;
          if (n - last_t !== 9) begin
            err++; $display("FAIL b2b_spacing: got %0d cycles, want 9", n - last_t);
          end
        end
        last_t = n; outs++;
      end
      acc_prev = in_vld_i && in_rdy_o;
      if (acc_prev) begin model_word(in_dat_i, e); q.push_back(e); end
      n++;
      tick;
    end
    in_vld_i = 1'b0; out_rdy_i = 1'b0;
    vec++;
    if (outs !== 4) begin
      err++; $display("FAIL b2b_count: got %0d outputs, want 4", outs);
    end
    n = 0;
    while (!out_vld_o && n < 50) begin n++; tick; end
    e = q.pop_front();
    vec++;
    if (out_vld_o !== 1'b1 || out_dat_o !== e) begin
      err++; $display("FAIL b2b_drain: vld=%b got %h, want 1 %h", out_vld_o, out_dat_o, e);
    end
    out_rdy_i = 1'b1;
    tick;
    out_rdy_i = 1'b0;
  endtask

  task automatic test_restart_drop;
    int n;
    in_vld_i = 1'b1; in_dat_i = 8'h5A;
    tick;
    in_vld_i = 1'b0;
    n = 0;
    while (!out_vld_o && n < 50) begin n++; tick; end
    vec++;
    if (out_vld_o !== 1'b1) begin
      err++; $display("FAIL drop_pending: vld=%b, want 1", out_vld_o);
    end
    init_seq(K2, V2, 1'b0);
  endtask

  task automatic test_enc_dec;
    logic [7:0] pt[4];
    logic [7:0] ct[4];
    logic [7:0] got;
    pt[0] = 8'h48; pt[1] = 8'h69; pt[2] = 8'hC3; pt[3] = 8'h0F;
    for (int i = 0; i < 4; i++) xfer(pt[i], 1'b0, ct[i]);
    init_seq(K2, V2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      xfer(ct[i], 1'b0, got);
      vec++;
      if (got !== pt[i]) begin
        err++; $display("FAIL decrypt_%0d: got %h, want %h", i, got, pt[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    key_i = K1; iv_i = V2; start_i = 1'b1;
    tick;
    start_i = 1'b0;
    repeat (5) tick;
    vec++;
    if (eng_ld_b_o !== 3'b010) begin
      err++; $display("FAIL mid_ld_iv: ld_b=%b, want 010", eng_ld_b_o);
    end
    #1 n_rst_i = 1'b0;
    #1;
    vec++;
    if ({rdy_o, in_rdy_o, out_vld_o, out_dat_o, eng_n_rst_o, eng_ce_o, eng_ld_dat_o, eng_ld_a_o, eng_ld_b_o, eng_dat_o} !== '0) begin
      err++; $display("FAIL async_reset: nrst=%b ce=%b a=%b b=%b dat=%h, want all 0", eng_n_rst_o, eng_ce_o, eng_ld_a_o, eng_ld_b_o, eng_ld_dat_o);
    end
    tick;
    n_rst_i = 1'b1;
    tick;
    vec++;
    if (eng_n_rst_o !== 1'b1 || eng_ce_o !== 1'b0 || eng_ld_b_o !== 3'b0 || rdy_o !== 1'b0) begin
      err++; $display("FAIL post_reset_idle: nrst=%b ce=%b b=%b rdy=%b, want 1 0 000 0", eng_n_rst_o, eng_ce_o, eng_ld_b_o, rdy_o);
    end
  endtask

  initial begin
    test_reset;
    init_seq(80'h0, 80'h0, 1'b0);
    test_keystream;
    test_stall;
    test_back_to_back;
    test_restart_drop;
    test_enc_dec;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
